// File: rtl/rf_1w64_1r32_read_arbiter_pkg.sv
// rf_arb_pkg: default widths and the round-robin pick function shared by the read arbiter
package rf_arb_pkg;

   localparam int N_PORTS_DEF     = 4;
   localparam int WADDR_WIDTH_DEF = 5;
   localparam int RDATA_WIDTH_DEF = 32;
   localparam int WDATA_WIDTH_DEF = 64;
   localparam int MAX_PORTS       = 16;
   localparam int PTR_W           = 4;

   // One-hot grant: first set bit of req at or above ptr, wrapping modulo n.
   // Vectors are sized for the largest supported arbiter; bits at n and above are ignored.
   function automatic logic [MAX_PORTS-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] req,
      input logic [PTR_W-1:0]     ptr,
      input logic [PTR_W:0]       n
   );
      logic [PTR_W-1:0] k;
      rr_pick = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         k = PTR_W'((int'(ptr) + i) % int'(n));
         if (i < int'(n) && rr_pick == '0 && req[k])
            rr_pick[k] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/rf_1w64_1r32_read_arbiter_core.sv
// rf_rr_arbiter_core: combinational round-robin pick, winner index and next pointer
module rf_rr_arbiter_core
   import rf_arb_pkg::*;
#(
   parameter int N_PORTS = N_PORTS_DEF,
   parameter int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [N_PORTS-1:0] gnt,
   output logic [PW-1:0]      idx,
   output logic [PW-1:0]      next_ptr
);

   logic [MAX_PORTS-1:0] req_ext;
   logic [MAX_PORTS-1:0] pick;
   logic [PTR_W-1:0]     ptr_ext;

   // widen to the package width, pick the winner and derive the pointer that follows it
   always_comb begin
      req_ext = '0;
      req_ext[N_PORTS-1:0] = req;
      ptr_ext = '0;
      ptr_ext[PW-1:0] = ptr;
      pick = rr_pick(req_ext, ptr_ext, (PTR_W+1)'(N_PORTS));
      gnt = pick[N_PORTS-1:0];
      idx = '0;
      for (int i = 0; i < MAX_PORTS; i++)
         if (pick[i]) idx = PW'(i);
      next_ptr = |pick ? ((idx == PW'(N_PORTS-1)) ? '0 : idx + 1'b1) : ptr;
   end

endmodule

// File: rtl/rf_1w64_1r32_read_arbiter.sv
// rf_1w64_1r32_read_arbiter: round-robin sharing of the 32-bit RF read port; write port passes through.
// Define RF_ARB_RAW_GUARD_EN to hold back a read whose row is written in the same cycle.
module rf_1w64_1r32_read_arbiter
   import rf_arb_pkg::*;
#(
   parameter int N_PORTS     = N_PORTS_DEF,
   parameter int WADDR_WIDTH = WADDR_WIDTH_DEF,
   parameter int RADDR_WIDTH = WADDR_WIDTH + 1,
   parameter int RDATA_WIDTH = RDATA_WIDTH_DEF,
   parameter int WDATA_WIDTH = WDATA_WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_PORTS-1:0]             req_i,
   input  logic [N_PORTS*RADDR_WIDTH-1:0] addr_i,
   output logic [N_PORTS-1:0]             gnt_o,
   output logic [N_PORTS-1:0]             r_valid_o,
   output logic [RDATA_WIDTH-1:0]         r_rdata_o,
   input  logic                           wr_en_i,
   input  logic [WADDR_WIDTH-1:0]         wr_addr_i,
   input  logic [WDATA_WIDTH-1:0]         wr_data_i,
   output logic                           rf_ReadEnable,
   output logic [RADDR_WIDTH-1:0]         rf_ReadAddr,
   input  logic [RDATA_WIDTH-1:0]         rf_ReadData,
   output logic                           rf_WriteEnable,
   output logic [WADDR_WIDTH-1:0]         rf_WriteAddr,
   output logic [WDATA_WIDTH-1:0]         rf_WriteData
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          next_ptr;
   logic [PW-1:0]          idx;
   logic [N_PORTS-1:0]     pick;
   logic [N_PORTS-1:0]     resp_owner;
   logic [RADDR_WIDTH-1:0] cand_addr;
   logic                   block;

   rf_rr_arbiter_core #(.N_PORTS(N_PORTS), .PW(PW)) u_core (
      .req      (req_i),
      .ptr      (rr_ptr),
      .gnt      (pick),
      .idx      (idx),
      .next_ptr (next_ptr)
   );

   // route the winner's address to the RF, optionally dropping the grant on a same-row write
   always_comb begin
      cand_addr = addr_i[idx*RADDR_WIDTH +: RADDR_WIDTH];
`ifdef RF_ARB_RAW_GUARD_EN
      block = wr_en_i && (cand_addr[RADDR_WIDTH-1:1] == wr_addr_i);
`else
      block = 1'b0;
`endif
      gnt_o = block ? '0 : pick;
      rf_ReadEnable = |gnt_o;
      rf_ReadAddr = rf_ReadEnable ? cand_addr : '0;
   end

   // advance the pointer past each grant and remember who owns next cycle's read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         resp_owner <= '0;
      end else begin
         if (|gnt_o) rr_ptr <= next_ptr;
         resp_owner <= gnt_o;
      end
   end

   assign r_valid_o      = resp_owner;
   assign r_rdata_o      = rf_ReadData;
   assign rf_WriteEnable = wr_en_i;
   assign rf_WriteAddr   = wr_addr_i;
   assign rf_WriteData   = wr_data_i;

endmodule

// File: tb/tb_rf_1w64_1r32_read_arbiter.sv
// tb_rf_1w64_1r32_read_arbiter: directed and random checks of the read arbiter against a behavioural model
module tb_rf_1w64_1r32_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N-1:0]  gnt_o, r_valid_o;
   logic [31:0]   r_rdata_o;
   logic          wr_en = 1'b0;
   logic [4:0]    wr_addr = '0;
   logic [63:0]   wr_data = '0;
   logic          rf_ReadEnable, rf_WriteEnable;
   logic [5:0]    rf_ReadAddr;
   logic [31:0]   rf_ReadData = '0;
   logic [4:0]    rf_WriteAddr;
   logic [63:0]   rf_WriteData;

   rf_1w64_1r32_read_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt_o),
      .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rf_ReadEnable(rf_ReadEnable),
      .rf_ReadAddr(rf_ReadAddr), .rf_ReadData(rf_ReadData),
      .rf_WriteEnable(rf_WriteEnable), .rf_WriteAddr(rf_WriteAddr),
      .rf_WriteData(rf_WriteData)
   );

   always #5 clk = ~clk;

   // register-file stand-in: 1-cycle read latency, same-cycle read sees old data
   logic [63:0] rf_mem [32];
   always @(posedge clk) begin
      if (rf_ReadEnable)
         rf_ReadData <= rf_ReadAddr[0] ? rf_mem[rf_ReadAddr[5:1]][63:32] : rf_mem[rf_ReadAddr[5:1]][31:0];
      if (rf_WriteEnable)
         rf_mem[rf_WriteAddr] <= rf_WriteData;
   end

   // reference model state
   logic [63:0] ref_mem [32];
   int          ref_ptr = 0;
   logic [N-1:0] last_eg = '0;
   int          gcount [N];
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [5:0] port_addr(input int p);
      logic [N*AW-1:0] a;
      a = addr;
      return a[p*AW +: AW];
   endfunction

   // one clock of stimulus already on the inputs: check comb outputs, then the response
   task automatic step();
      logic [N-1:0] eg;
      logic [5:0]   ea;
      logic [31:0]  ed;
      int           gi;
      eg = '0;
      ea = '0;
      gi = -1;
      for (int i = 0; i < N; i++) begin
         int p;
         p = (ref_ptr + i) % N;
         if (gi < 0 && req[p]) begin
            gi = p;
            ea = port_addr(p);
         end
      end
`ifdef RF_ARB_RAW_GUARD_EN
      if (gi >= 0 && wr_en && ea[5:1] == wr_addr) gi = -1;
`endif
      if (gi >= 0) eg[gi] = 1'b1;
      else ea = '0;
      #1;
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("ren", 64'(rf_ReadEnable), 64'(gi >= 0));
      chk("raddr", 64'(rf_ReadAddr), 64'(ea));
      chk("wen", 64'(rf_WriteEnable), 64'(wr_en));
      chk("waddr", 64'(rf_WriteAddr), 64'(wr_addr));
      chk("wdata", rf_WriteData, wr_data);
      ed = ea[0] ? ref_mem[ea[5:1]][63:32] : ref_mem[ea[5:1]][31:0];
      @(posedge clk);
      if (gi >= 0) begin
         ref_ptr = (gi + 1) % N;
         gcount[gi]++;
      end
      if (wr_en) ref_mem[wr_addr] = wr_data;
      last_eg = eg;
      #1;
      chk("rvalid", 64'(r_valid_o), 64'(eg));
      if (gi >= 0) chk("rdata", 64'(r_rdata_o), 64'(ed));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(r_valid_o), 64'd0);
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      rst_n = 1'b1;
      ref_ptr = 0;
      last_eg = '0;
   endtask

   task automatic set_addr(input int p, input logic [5:0] a);
      addr[p*AW +: AW] = a;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         rf_mem[r]  = {$urandom, $urandom};
         ref_mem[r] = rf_mem[r];
      end
      for (int p = 0; p < N; p++) gcount[p] = 0;
      do_reset();

      // single request to port 2, hi half of row 5
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hCAFE_F00D_1234_5678;
      step();
      wr_en = 1'b0;
      req = 4'b0100;
      set_addr(2, 6'h0B);
      step();
      req = '0;
      step();

      // all requesting from reset: strict rotation, equal share
      do_reset();
      for (int p = 0; p < N; p++) begin
         gcount[p] = 0;
         set_addr(p, 6'(p * 9 + 1));
      end
      req = '1;
      for (int c = 0; c < 40; c++) step();
      for (int p = 0; p < N; p++) chk("fair", 64'(gcount[p]), 64'd10);

      // ports 1 and 3 with the pointer at 2
      do_reset();
      req = 4'b0010;
      step();
      req = 4'b1010;
      step();
      req = 4'b0010;
      step();
      req = 4'b0110;
      step();
      req = '0;

      // write row 7 then read both halves
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD_BEEF_0123_4567;
      step();
      wr_en = 1'b0;
      req = 4'b0001;
      set_addr(0, 6'h0E);
      step();
      set_addr(0, 6'h0F);
      step();
      req = '0;
      step();

      // same-cycle write to row 3 and read of word 7
      req = 4'b0001;
      set_addr(0, 6'h07);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h0BAD_C0DE_5555_AAAA;
      step();
      wr_en = 1'b0;
      if (last_eg != '0) req = '0;
      step();
      req = '0;
      step();

      // reset the cycle after a grant
      do_reset();
      req = 4'b0100;
      set_addr(2, 6'h11);
      step();
      req = 4'b1000;
      set_addr(3, 6'h12);
      step();
      req = 4'b1100;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 64'(r_valid_o), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_valid", 64'(r_valid_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_ptr = 0;
      last_eg = '0;
      step();
      req = '0;
      step();

      // random traffic honouring the handshake
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < N; p++) begin
            if (req[p] && !last_eg[p]) begin
               if ($urandom_range(7) == 0) req[p] = 1'b0;
            end else begin
               req[p] = 1'($urandom);
               set_addr(p, 6'($urandom));
            end
         end
         wr_en = 1'($urandom);
         wr_addr = ($urandom_range(3) == 0) ? port_addr($urandom_range(N-1))[5:1] : 5'($urandom);
         wr_data = {$urandom, $urandom};
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
